time_set_controller: RTL
========================

// Module: time_set_controller
// PURPOSE
//  Mode/time controller behind the button debouncer. Edge-detects the debounced
//  hour, minute, mode and alarm-enable levels and runs a RUN/SET_TIME/SET_ALARM FSM.
//  Keeps the time-of-day and alarm registers and raises the alarm ring output.
//  Feeds the display driver and the audio block; runs in the 5 MHz clk_5M domain.
// PARAMETERS
//  HOURS_MAX  23  last hour value before wrap to 0 (24 h format)
//  RING_SECS  60  seconds alarm_ring stays high if not dismissed (1..255)
// PORTS
//  clk          in   1  5 MHz system clock, all logic on posedge
//  rst_n        in   1  asynchronous reset, active low
//  tick_1hz     in   1  one-clk strobe, once per second
//  hours_in     in   1  debounced hour-button level (high many clk cycles)
//  minutes_in   in   1  debounced minute-button level
//  mode_in      in   1  debounced mode-button level
//  enable_a_in  in   1  debounced alarm-enable-button level
//  time_hh      out  5  current hour 0..HOURS_MAX
//  time_mm      out  6  current minute 0..59
//  time_ss      out  6  current second 0..59
//  alarm_hh     out  5  alarm hour
//  alarm_mm     out  6  alarm minute
//  mode         out  2  0=RUN 1=SET_TIME 2=SET_ALARM (3 never driven)
//  alarm_armed  out  1  alarm enabled
//  alarm_ring   out  1  alarm sounding
// BEHAVIOUR
//  Reset: all outputs 0, FSM=RUN, edge-detect history regs 0.
//  Every button input goes through a 1-flop history. A press is in&~prev. It is
//  exactly one clk wide, one cycle after the input rises. Held levels give one press.
//  FSM: RUN -mode press-> SET_TIME -mode press-> SET_ALARM -mode press-> RUN.
//  RUN: on tick_1hz, ss+1. At 59 it wraps to 0 and carries to mm. mm at 59 wraps and
//   carries to hh. hh at HOURS_MAX wraps to 0. Hour/minute presses are ignored.
//  SET_TIME: ss is forced to 0 on entry and held at 0. tick_1hz is ignored.
//   Hour press: hh+1 mod (HOURS_MAX+1). Minute press: mm+1 mod 60, no carry into hh.
//   On return to RUN, counting resumes from the next tick_1hz.
//  SET_ALARM: hour and minute presses step alarm_hh/alarm_mm the same way. Time keeps running.
//  Hour and minute presses in the same cycle both apply.
//  enable_a press in any mode toggles alarm_armed. If alarm_ring=1, the press
//   instead clears alarm_ring and leaves alarm_armed unchanged.
//  Ring start: in RUN with alarm_armed, on the tick that makes hh:mm:ss equal
//   alarm_hh:alarm_mm:00, alarm_ring=1 the cycle after that tick. The ring
//   second counter loads 0.
//  While ringing, each tick_1hz increments the counter. At RING_SECS, alarm_ring=0.
//   Any hour, minute or mode press also clears alarm_ring. That press still does
//   its normal action.
//  alarm_ring is forced 0 whenever alarm_armed=0 or mode!=RUN.
//  Ring start and a dismiss press in the same cycle: the dismiss wins.
//  tick_1hz and a mode press in the same cycle in RUN: the tick applies first, then the mode changes.
//  Reset mid-operation: everything returns to reset values at once, without waiting for clk.
//  Latency: press to register update is 2 clk from the input rising edge.
// STRUCTURE
//  Shared package time_pkg: mode encodings MODE_RUN/MODE_SET_TIME/MODE_SET_ALARM,
//  widths HH_W=5 and MM_W=6, and the constant SEC_MAX=59.
//  One sub-module, rise_detect (1-bit history flop plus AND), instantiated x4.
//  The FSM, counters and ring logic live in the top module.
// TESTING
//  1 Reset, then hold mode_in high 1000 clk -> mode=1 exactly once; ss=0 afterwards.
//  2 SET_TIME, 25 hour presses -> time_hh=1; 61 minute presses -> mm=1, hh unchanged.
//  3 RUN at 23:59:58, two tick_1hz -> 23:59:59, then 00:00:00.
//  4 alarm 07:30, armed, time 07:29:59, one tick -> alarm_ring=1 next clk;
//    60 more ticks -> alarm_ring=0 and alarm_armed still 1.
//  5 Ringing, enable_a press -> ring=0, armed=1; next enable_a press -> armed=0.
//  6 rst_n pulsed low mid-ring while clk is stopped -> all outputs 0 at once.

Source files
------------

// File: rtl/time_pkg.sv
// Shared encodings, widths and wrap helpers for the time-of-day / alarm controller.
package time_pkg;

  localparam int HH_W = 5;
  localparam int MM_W = 6;
  localparam logic [MM_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_e;

  // Minutes and seconds share the same 0..59 wrap.
  function automatic logic [MM_W-1:0] inc_sexa(input logic [MM_W-1:0] v);
    return (v >= SEC_MAX) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [HH_W-1:0] inc_hour(input logic [HH_W-1:0] v,
                                               input logic [HH_W-1:0] v_max);
    return (v >= v_max) ? 5'd0 : v + 5'd1;
  endfunction

endpackage

// File: rtl/time_set_controller_rise_detect.sv
// Rising-edge detector for a debounced button level; the press pulse is registered
// so it appears one clk after the level rises and lasts exactly one clk.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_press
);

  logic r_prev;
  logic r_press;

  // History flop and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_prev  <= i_level;
      r_press <= i_level & ~r_prev;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/time_set_controller.sv
// Mode FSM, time-of-day counter, alarm registers and alarm ring control behind
// the button debouncer.
module time_set_controller
  import time_pkg::*;
#(
  parameter int HOURS_MAX = 23,
  parameter int RING_SECS = 60
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_1hz,
  input  logic            hours_in,
  input  logic            minutes_in,
  input  logic            mode_in,
  input  logic            enable_a_in,
  output logic [HH_W-1:0] time_hh,
  output logic [MM_W-1:0] time_mm,
  output logic [MM_W-1:0] time_ss,
  output logic [HH_W-1:0] alarm_hh,
  output logic [MM_W-1:0] alarm_mm,
  output logic [1:0]      mode,
  output logic            alarm_armed,
  output logic            alarm_ring
);

  localparam logic [HH_W-1:0] HH_MAX_C = HH_W'(HOURS_MAX);
  localparam logic [7:0]      RING_C   = 8'(RING_SECS);

  logic w_p_hr, w_p_mn, w_p_md, w_p_en;

  rise_detect u_rd_hr (.clk(clk), .rst_n(rst_n), .i_level(hours_in),    .o_press(w_p_hr));
  rise_detect u_rd_mn (.clk(clk), .rst_n(rst_n), .i_level(minutes_in),  .o_press(w_p_mn));
  rise_detect u_rd_md (.clk(clk), .rst_n(rst_n), .i_level(mode_in),     .o_press(w_p_md));
  rise_detect u_rd_en (.clk(clk), .rst_n(rst_n), .i_level(enable_a_in), .o_press(w_p_en));

  mode_e           r_mode;
  logic [HH_W-1:0] r_hh, r_ahh;
  logic [MM_W-1:0] r_mm, r_ss, r_amm;
  logic            r_armed, r_ring;
  logic [7:0]      r_ring_cnt;

  logic [HH_W-1:0] w_hh_nxt, w_ahh_nxt;
  logic [MM_W-1:0] w_mm_nxt, w_ss_nxt, w_amm_nxt;
  logic            w_enter_set;
  logic            w_match, w_ring_start, w_dismiss;
  logic            w_armed_nxt, w_ring_nxt;
  logic [7:0]      w_ring_cnt_inc, w_ring_cnt_nxt;

  // Time-of-day next value: edited in SET_TIME, otherwise counted by the 1 Hz tick.
  always_comb begin
    w_hh_nxt = r_hh;
    w_mm_nxt = r_mm;
    w_ss_nxt = r_ss;
    if (r_mode == MODE_SET_TIME) begin
      w_ss_nxt = 6'd0;
      if (w_p_hr) w_hh_nxt = inc_hour(r_hh, HH_MAX_C);
      else        w_hh_nxt = r_hh;
      if (w_p_mn) w_mm_nxt = inc_sexa(r_mm);
      else        w_mm_nxt = r_mm;
    end else if (tick_1hz) begin
      w_ss_nxt = inc_sexa(r_ss);
      if (r_ss == SEC_MAX) begin
        w_mm_nxt = inc_sexa(r_mm);
        if (r_mm == SEC_MAX) w_hh_nxt = inc_hour(r_hh, HH_MAX_C);
        else                 w_hh_nxt = r_hh;
      end else begin
        w_mm_nxt = r_mm;
        w_hh_nxt = r_hh;
      end
    end else begin
      w_hh_nxt = r_hh;
      w_mm_nxt = r_mm;
      w_ss_nxt = r_ss;
    end
  end

  // Alarm time is only editable in SET_ALARM.
  always_comb begin
    w_ahh_nxt = r_ahh;
    w_amm_nxt = r_amm;
    if (r_mode == MODE_SET_ALARM) begin
      if (w_p_hr) w_ahh_nxt = inc_hour(r_ahh, HH_MAX_C);
      else        w_ahh_nxt = r_ahh;
      if (w_p_mn) w_amm_nxt = inc_sexa(r_amm);
      else        w_amm_nxt = r_amm;
    end else begin
      w_ahh_nxt = r_ahh;
      w_amm_nxt = r_amm;
    end
  end

  // Arm toggle and ring control; any press dismisses, and a dismiss beats a ring start.
  always_comb begin
    w_enter_set    = (r_mode == MODE_RUN) && w_p_md;
    w_match        = (w_hh_nxt == r_ahh) && (w_mm_nxt == r_amm) && (w_ss_nxt == 6'd0);
    w_ring_start   = (r_mode == MODE_RUN) && r_armed && tick_1hz && w_match;
    w_dismiss      = w_p_hr | w_p_mn | w_p_md | w_p_en;
    w_ring_cnt_inc = r_ring_cnt + 8'd1;
    w_ring_nxt     = r_ring;
    w_ring_cnt_nxt = r_ring_cnt;
    if (w_p_en && !r_ring) w_armed_nxt = ~r_armed;
    else                   w_armed_nxt = r_armed;
    if (w_dismiss || !w_armed_nxt || (r_mode != MODE_RUN)) begin
      w_ring_nxt = 1'b0;
    end else if (w_ring_start) begin
      w_ring_nxt     = 1'b1;
      w_ring_cnt_nxt = 8'd0;
    end else if (r_ring && tick_1hz) begin
      w_ring_cnt_nxt = w_ring_cnt_inc;
      if (w_ring_cnt_inc == RING_C) w_ring_nxt = 1'b0;
      else                          w_ring_nxt = 1'b1;
    end else begin
      w_ring_nxt     = r_ring;
      w_ring_cnt_nxt = r_ring_cnt;
    end
  end

  // Mode FSM plus all time/alarm/ring state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= MODE_RUN;
      r_hh       <= 5'd0;
      r_mm       <= 6'd0;
      r_ss       <= 6'd0;
      r_ahh      <= 5'd0;
      r_amm      <= 6'd0;
      r_armed    <= 1'b0;
      r_ring     <= 1'b0;
      r_ring_cnt <= 8'd0;
    end else begin
      if (w_p_md) begin
        case (r_mode)
          MODE_RUN:       r_mode <= MODE_SET_TIME;
          MODE_SET_TIME:  r_mode <= MODE_SET_ALARM;
          MODE_SET_ALARM: r_mode <= MODE_RUN;
          default:        r_mode <= MODE_RUN;
        endcase
      end else begin
        r_mode <= r_mode;
      end
      r_hh       <= w_hh_nxt;
      r_mm       <= w_mm_nxt;
      r_ss       <= w_enter_set ? 6'd0 : w_ss_nxt;
      r_ahh      <= w_ahh_nxt;
      r_amm      <= w_amm_nxt;
      r_armed    <= w_armed_nxt;
      r_ring     <= w_ring_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
    end
  end

  assign time_hh     = r_hh;
  assign time_mm     = r_mm;
  assign time_ss     = r_ss;
  assign alarm_hh    = r_ahh;
  assign alarm_mm    = r_amm;
  assign mode        = r_mode;
  assign alarm_armed = r_armed;
  assign alarm_ring  = r_ring;

endmodule
